// File: rtl/rec_pwm_sequencer_pkg.sv
// Shared types and constants for the rectifier PWM run/fault sequencer.
// State encodings, fault-cause codes, counter widths and a saturating trip increment.
package rec_pwm_sequencer_pkg;

   localparam int TMR_W   = 16;
   localparam int TRIP_W  = 4;
   localparam int RETRY_W = 3;
   localparam int CAUSE_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRECHG = 3'd1,
      ST_DELAY  = 3'd2,
      ST_RUN    = 3'd3,
      ST_RETRY  = 3'd4,
      ST_FAULT  = 3'd5
   } seq_state_t;

   localparam logic [CAUSE_W-1:0] CAUSE_NONE   = 2'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_PRECHG = 2'd1;
   localparam logic [CAUSE_W-1:0] CAUSE_TRIPS  = 2'd2;

   localparam logic [TRIP_W-1:0]  TRIP_SAT     = 4'd15;

   function automatic logic [TRIP_W-1:0] trip_sat_inc(input logic [TRIP_W-1:0] i_val);
      if (i_val == TRIP_SAT) begin
         return i_val;
      end else begin
         return i_val + 4'd1;
      end
   endfunction

endpackage

// File: rtl/rec_pwm_sequencer_timer.sv
// Clearable, enabled 16-bit up-counter that saturates at all-ones.
// Raises o_eq while the count matches the supplied compare value.
module rec_pwm_sequencer_timer #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_cmp,
   output logic         o_eq
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] MAX = {W{1'b1}};

   logic [W-1:0] r_count;

   // Count register: clear wins over increment, hold at saturation
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= {W{1'b0}};
      end else if (i_clr) begin
         r_count <= {W{1'b0}};
      end else if (i_en && (r_count != MAX)) begin
         r_count <= r_count + ONE;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_eq = (r_count == i_cmp);

endmodule

// File: rtl/rec_pwm_sequencer.sv
// Run/fault supervisor for the rectifier PWM stage: start-up sequencing, PwmEn gating,
// windowed current-limit trip counting and timed retries ahead of a latched hard fault.
module rec_pwm_sequencer
   import rec_pwm_sequencer_pkg::*;
#(
   parameter logic [TMR_W-1:0]   PRECHG_TIMEOUT = 16'd50000,
   parameter logic [TMR_W-1:0]   ENABLE_DELAY   = 16'd1000,
   parameter logic [TMR_W-1:0]   WIN_TIME       = 16'd10000,
   parameter logic [TRIP_W-1:0]  TRIP_MAX       = 4'd8,
   parameter logic [TMR_W-1:0]   RETRY_TIME     = 16'd20000,
   parameter logic [RETRY_W-1:0] RETRY_MAX      = 3'd3
) (
   input  logic               clk_100,
   input  logic               RSTn,
   input  logic               StartCmd,
   input  logic               StopCmd,
   input  logic               FaultClr,
   input  logic               BusReady,
   input  logic               IP_LMT,
   input  logic               IN_LMT,
   output logic               PwmEn,
   output logic [2:0]         SeqState,
   output logic               FaultLatched,
   output logic [CAUSE_W-1:0] FaultCause,
   output logic [TRIP_W-1:0]  TripCount,
   output logic [RETRY_W-1:0] RetryCount
);

   logic               r_ip_s1, r_ip_s2, r_ip_d;
   logic               r_in_s1, r_in_s2, r_in_d;
   logic               w_trip_evt;

   seq_state_t         r_state, w_state_nxt;
   logic [TMR_W-1:0]   w_tmr_cmp;
   logic               w_tmr_eq, w_tmr_clr;
   logic               w_win_eq, w_win_clr;

   logic [TRIP_W-1:0]  r_trip_cnt, w_trip_nxt;
   logic [RETRY_W-1:0] r_retry_cnt, w_retry_nxt;
   logic [CAUSE_W-1:0] r_cause, w_cause_nxt;
   logic               r_pwm_en, w_pwm_nxt;
   logic               r_fault, w_fault_nxt;

   // Two-flop synchronisers plus one delay stage for falling-edge detection; idle level is high
   always_ff @(posedge clk_100 or negedge RSTn) begin
      if (!RSTn) begin
         r_ip_s1 <= 1'b1;
         r_ip_s2 <= 1'b1;
         r_ip_d  <= 1'b1;
         r_in_s1 <= 1'b1;
         r_in_s2 <= 1'b1;
         r_in_d  <= 1'b1;
      end else begin
         r_ip_s1 <= IP_LMT;
         r_ip_s2 <= r_ip_s1;
         r_ip_d  <= r_ip_s2;
         r_in_s1 <= IN_LMT;
         r_in_s2 <= r_in_s1;
         r_in_d  <= r_in_s2;
      end
   end

   // Coincident edges on both limits collapse into a single trip event
   assign w_trip_evt = (r_ip_d & ~r_ip_s2) | (r_in_d & ~r_in_s2);

   // State-timer compare value for the state currently being timed
   always_comb begin
      w_tmr_cmp = 16'hFFFF;
      case (r_state)
         ST_PRECHG: w_tmr_cmp = PRECHG_TIMEOUT;
         ST_DELAY:  w_tmr_cmp = ENABLE_DELAY;
         ST_RETRY:  w_tmr_cmp = RETRY_TIME;
         default:   w_tmr_cmp = 16'hFFFF;
      endcase
   end

   assign w_tmr_clr = (w_state_nxt != r_state);
   assign w_win_clr = (r_state != ST_RUN) || w_win_eq;

   rec_pwm_sequencer_timer #(.W(TMR_W)) u_state_tmr (
      .i_clk   (clk_100),
      .i_rst_n (RSTn),
      .i_clr   (w_tmr_clr),
      .i_en    (1'b1),
      .i_cmp   (w_tmr_cmp),
      .o_eq    (w_tmr_eq)
   );

   rec_pwm_sequencer_timer #(.W(TMR_W)) u_win_tmr (
      .i_clk   (clk_100),
      .i_rst_n (RSTn),
      .i_clr   (w_win_clr),
      .i_en    (1'b1),
      .i_cmp   (WIN_TIME),
      .o_eq    (w_win_eq)
   );

   // State register
   always_ff @(posedge clk_100 or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; StopCmd outranks everything except the latched fault
   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry_cnt;
      w_cause_nxt = r_cause;
      case (r_state)
         ST_IDLE: begin
            if (StartCmd && !StopCmd) begin
               w_state_nxt = ST_PRECHG;
               w_retry_nxt = 3'd0;
               w_cause_nxt = CAUSE_NONE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_PRECHG: begin
            if (StopCmd) begin
               w_state_nxt = ST_IDLE;
            end else if (BusReady) begin
               w_state_nxt = ST_DELAY;
            end else if (w_tmr_eq) begin
               w_state_nxt = ST_FAULT;
               w_cause_nxt = CAUSE_PRECHG;
            end else begin
               w_state_nxt = ST_PRECHG;
            end
         end
         ST_DELAY: begin
            if (StopCmd) begin
               w_state_nxt = ST_IDLE;
            end else if (!BusReady) begin
               w_state_nxt = ST_PRECHG;
            end else if (w_tmr_eq) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_DELAY;
            end
         end
         ST_RUN: begin
            if (StopCmd) begin
               w_state_nxt = ST_IDLE;
            end else if (r_trip_cnt >= TRIP_MAX) begin
               if (r_retry_cnt < RETRY_MAX) begin
                  w_state_nxt = ST_RETRY;
                  w_retry_nxt = r_retry_cnt + 3'd1;
               end else begin
                  w_state_nxt = ST_FAULT;
                  w_cause_nxt = CAUSE_TRIPS;
               end
            end else if (!BusReady) begin
               w_state_nxt = ST_PRECHG;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RETRY: begin
            if (StopCmd) begin
               w_state_nxt = ST_IDLE;
            end else if (w_tmr_eq) begin
               w_state_nxt = ST_PRECHG;
            end else begin
               w_state_nxt = ST_RETRY;
            end
         end
         ST_FAULT: begin
            if (FaultClr) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_FAULT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Trip counter: live only while staying in RUN; a window wrap restarts it, keeping a same-cycle event
   always_comb begin
      if ((r_state != ST_RUN) || (w_state_nxt != ST_RUN)) begin
         w_trip_nxt = 4'd0;
      end else if (w_win_eq) begin
         w_trip_nxt = w_trip_evt ? 4'd1 : 4'd0;
      end else if (w_trip_evt) begin
         w_trip_nxt = trip_sat_inc(r_trip_cnt);
      end else begin
         w_trip_nxt = r_trip_cnt;
      end
   end

   // Outputs decoded from the next state so they change on the same edge as SeqState
   always_comb begin
      w_pwm_nxt   = (w_state_nxt == ST_RUN);
      w_fault_nxt = (w_state_nxt == ST_FAULT);
   end

   // Counter, cause and output registers; reset drops PwmEn without waiting for a clock
   always_ff @(posedge clk_100 or negedge RSTn) begin
      if (!RSTn) begin
         r_trip_cnt  <= 4'd0;
         r_retry_cnt <= 3'd0;
         r_cause     <= CAUSE_NONE;
         r_pwm_en    <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_trip_cnt  <= w_trip_nxt;
         r_retry_cnt <= w_retry_nxt;
         r_cause     <= w_cause_nxt;
         r_pwm_en    <= w_pwm_nxt;
         r_fault     <= w_fault_nxt;
      end
   end

   assign PwmEn        = r_pwm_en;
   assign SeqState     = r_state;
   assign FaultLatched = r_fault;
   assign FaultCause   = r_cause;
   assign TripCount    = r_trip_cnt;
   assign RetryCount   = r_retry_cnt;

endmodule

// File: tb/tb_rec_pwm_sequencer.sv
// Self-checking bench for rec_pwm_sequencer with shortened timing parameters.
module tb_rec_pwm_sequencer;

   localparam logic [15:0] P_PRECHG = 16'd3000;
   localparam logic [15:0] P_EN     = 16'd100;
   localparam logic [15:0] P_WIN    = 16'd2000;
   localparam logic [3:0]  P_TRIP   = 4'd8;
   localparam logic [15:0] P_RETRY  = 16'd500;
   localparam logic [2:0]  P_RMAX   = 3'd3;

   logic       clk_100 = 1'b0;
   logic       RSTn, StartCmd, StopCmd, FaultClr, BusReady, IP_LMT, IN_LMT;
   logic       PwmEn, FaultLatched;
   logic [2:0] SeqState;
   logic [1:0] FaultCause;
   logic [3:0] TripCount;
   logic [2:0] RetryCount;

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];
   int cyc = 0;
   int run_start = 0;

   rec_pwm_sequencer #(
      .PRECHG_TIMEOUT (P_PRECHG),
      .ENABLE_DELAY   (P_EN),
      .WIN_TIME       (P_WIN),
      .TRIP_MAX       (P_TRIP),
      .RETRY_TIME     (P_RETRY),
      .RETRY_MAX      (P_RMAX)
   ) dut (
      .clk_100      (clk_100),
      .RSTn         (RSTn),
      .StartCmd     (StartCmd),
      .StopCmd      (StopCmd),
      .FaultClr     (FaultClr),
      .BusReady     (BusReady),
      .IP_LMT       (IP_LMT),
      .IN_LMT       (IN_LMT),
      .PwmEn        (PwmEn),
      .SeqState     (SeqState),
      .FaultLatched (FaultLatched),
      .FaultCause   (FaultCause),
      .TripCount    (TripCount),
      .RetryCount   (RetryCount)
   );

   always #5 clk_100 = ~clk_100;

   always @(posedge clk_100) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_100);
      #1;
   endtask

   task automatic pulse(input logic both);
      IP_LMT = 1'b0;
      if (both) IN_LMT = 1'b0;
      tick(4);
      IP_LMT = 1'b1;
      IN_LMT = 1'b1;
      tick(4);
   endtask

   task automatic go_run();
      int n;
      StartCmd = 1'b1;
      BusReady = 1'b1;
      n = 0;
      while (PwmEn !== 1'b1 && n < 2000) begin
         tick(1);
         n++;
      end
      run_start = cyc;
   endtask

   task automatic test_reset();
      RSTn = 1'b0; StartCmd = 1'b0; StopCmd = 1'b0; FaultClr = 1'b0;
      BusReady = 1'b0; IP_LMT = 1'b1; IN_LMT = 1'b1;
      #22;
      n_checks++;
      if ({PwmEn, SeqState, FaultLatched, FaultCause, TripCount, RetryCount} !== 14'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {PwmEn, SeqState, FaultLatched, FaultCause, TripCount, RetryCount});
      end
      RSTn = 1'b1;
      tick(3);
      n_checks++;
      if (SeqState !== 3'd0) begin
         n_errors++;
         $display("FAIL reset_idle_hold: got %0d expected 0", SeqState);
      end
   endtask

   task automatic test_startup();
      int n;
      StartCmd = 1'b1;
      BusReady = 1'b0;
      tick(1);
      n_checks++;
      if (SeqState !== 3'd1) begin
         n_errors++;
         $display("FAIL start_prechg: got %0d expected 1", SeqState);
      end
      tick(98);
      BusReady = 1'b1;
      tick(1);
      n_checks++;
      if (SeqState !== 3'd2) begin
         n_errors++;
         $display("FAIL start_delay: got %0d expected 2", SeqState);
      end
      exp_q.push_back(int'(P_EN) + 1);
      n = 0;
      while (PwmEn !== 1'b1 && n < 1000) begin
         tick(1);
         n++;
      end
      n_checks++;
      if (n !== exp_q.pop_front()) begin
         n_errors++;
         $display("FAIL enable_delay: got %0d cycles expected %0d", n, int'(P_EN) + 1);
      end
      n_checks++;
      if (SeqState !== 3'd3) begin
         n_errors++;
         $display("FAIL start_run: got %0d expected 3", SeqState);
      end
   endtask

   task automatic test_stop();
      StopCmd = 1'b1;
      tick(1);
      n_checks++;
      if ({PwmEn, SeqState} !== 4'b0_000) begin
         n_errors++;
         $display("FAIL stop_run: got pwm=%0d state=%0d expected pwm=0 state=0", PwmEn, SeqState);
      end
      StopCmd = 1'b0;
      StartCmd = 1'b0;
      tick(2);
      n_checks++;
      if (SeqState !== 3'd0) begin
         n_errors++;
         $display("FAIL stop_idle_hold: got %0d expected 0", SeqState);
      end
   endtask

   task automatic test_trip_retry();
      int n;
      go_run();
      n_checks++;
      if (SeqState !== 3'd3) begin
         n_errors++;
         $display("FAIL trip_run_entry: got %0d expected 3", SeqState);
      end
      for (int k = 1; k <= 7; k++) begin
         exp_q.push_back(k);
         pulse(1'b0);
         n_checks++;
         if (int'(TripCount) !== exp_q.pop_front()) begin
            n_errors++;
            $display("FAIL trip_count_%0d: got %0d expected %0d", k, TripCount, k);
         end
      end
      IP_LMT = 1'b0;
      n = 0;
      while (SeqState !== 3'd4 && n < 20) begin
         tick(1);
         n++;
      end
      n_checks++;
      if (n !== 4) begin
         n_errors++;
         $display("FAIL trip_to_retry_latency: got %0d expected 4", n);
      end
      n_checks++;
      if ({PwmEn, RetryCount, TripCount} !== {1'b0, 3'd1, 4'd0}) begin
         n_errors++;
         $display("FAIL retry_entry: got pwm=%0d retry=%0d trip=%0d expected 0 1 0",
                  PwmEn, RetryCount, TripCount);
      end
      IP_LMT = 1'b1;
      exp_q.push_back(int'(P_RETRY) + 1);
      n = 0;
      while (SeqState === 3'd4 && n < int'(P_RETRY) + 50) begin
         tick(1);
         n++;
      end
      n_checks++;
      if (n !== exp_q.pop_front()) begin
         n_errors++;
         $display("FAIL retry_time: got %0d expected %0d", n, int'(P_RETRY) + 1);
      end
      n_checks++;
      if (SeqState !== 3'd1) begin
         n_errors++;
         $display("FAIL retry_to_prechg: got %0d expected 1", SeqState);
      end
   endtask

   task automatic test_window();
      go_run();
      n_checks++;
      if ({SeqState, RetryCount} !== {3'd3, 3'd1}) begin
         n_errors++;
         $display("FAIL window_run_entry: got state=%0d retry=%0d expected 3 1", SeqState, RetryCount);
      end
      for (int k = 0; k < 7; k++) pulse(1'b0);
      while (cyc < run_start + int'(P_WIN) - 2) tick(1);
      n_checks++;
      if (TripCount !== 4'd7) begin
         n_errors++;
         $display("FAIL window_pre_wrap: got %0d expected 7", TripCount);
      end
      IP_LMT = 1'b0;
      tick(3);
      n_checks++;
      if ({SeqState, TripCount} !== {3'd3, 4'd1}) begin
         n_errors++;
         $display("FAIL window_wrap_event: got state=%0d trip=%0d expected 3 1", SeqState, TripCount);
      end
      IP_LMT = 1'b1;
      tick(4);
      pulse(1'b1);
      n_checks++;
      if (TripCount !== 4'd2) begin
         n_errors++;
         $display("FAIL simultaneous_edges: got %0d expected 2", TripCount);
      end
   endtask

   task automatic test_retries_fault();
      int k;
      int n;
      int exp_st;
      int exp_rc;
      exp_q.push_back(4); exp_q.push_back(2);
      exp_q.push_back(4); exp_q.push_back(3);
      exp_q.push_back(5); exp_q.push_back(3);
      for (int b = 0; b < 3; b++) begin
         k = 0;
         while (SeqState === 3'd3 && k < 12) begin
            pulse(1'b0);
            k++;
         end
         exp_st = exp_q.pop_front();
         exp_rc = exp_q.pop_front();
         n_checks++;
         if (int'(SeqState) !== exp_st || int'(RetryCount) !== exp_rc) begin
            n_errors++;
            $display("FAIL burst_%0d: got state=%0d retry=%0d expected %0d %0d",
                     b, SeqState, RetryCount, exp_st, exp_rc);
         end
         if (SeqState === 3'd4) begin
            n = 0;
            while (PwmEn !== 1'b1 && n < 2000) begin
               tick(1);
               n++;
            end
         end
      end
      n_checks++;
      if ({PwmEn, FaultLatched, FaultCause} !== {1'b0, 1'b1, 2'd2}) begin
         n_errors++;
         $display("FAIL fault_trips: got pwm=%0d latched=%0d cause=%0d expected 0 1 2",
                  PwmEn, FaultLatched, FaultCause);
      end
      StartCmd = 1'b1;
      StopCmd = 1'b1;
      tick(5);
      StopCmd = 1'b0;
      tick(5);
      n_checks++;
      if (SeqState !== 3'd5) begin
         n_errors++;
         $display("FAIL fault_sticky: got %0d expected 5", SeqState);
      end
      StartCmd = 1'b0;
      FaultClr = 1'b1;
      tick(1);
      FaultClr = 1'b0;
      n_checks++;
      if ({SeqState, FaultLatched} !== {3'd0, 1'b0}) begin
         n_errors++;
         $display("FAIL fault_clear: got state=%0d latched=%0d expected 0 0", SeqState, FaultLatched);
      end
   endtask

   task automatic test_prechg_timeout();
      int n;
      bit pwm_seen;
      BusReady = 1'b0;
      StartCmd = 1'b1;
      tick(1);
      n_checks++;
      if ({SeqState, FaultCause, RetryCount} !== {3'd1, 2'd0, 3'd0}) begin
         n_errors++;
         $display("FAIL restart_clears: got state=%0d cause=%0d retry=%0d expected 1 0 0",
                  SeqState, FaultCause, RetryCount);
      end
      exp_q.push_back(int'(P_PRECHG) + 1);
      n = 0;
      pwm_seen = 1'b0;
      while (SeqState === 3'd1 && n < int'(P_PRECHG) + 100) begin
         tick(1);
         n++;
         if (PwmEn !== 1'b0) pwm_seen = 1'b1;
      end
      n_checks++;
      if (n !== exp_q.pop_front()) begin
         n_errors++;
         $display("FAIL prechg_timeout: got %0d expected %0d", n, int'(P_PRECHG) + 1);
      end
      n_checks++;
      if ({SeqState, FaultLatched, FaultCause, pwm_seen} !== {3'd5, 1'b1, 2'd1, 1'b0}) begin
         n_errors++;
         $display("FAIL prechg_fault: got state=%0d latched=%0d cause=%0d pwm_seen=%0d expected 5 1 1 0",
                  SeqState, FaultLatched, FaultCause, pwm_seen);
      end
      StartCmd = 1'b0;
      FaultClr = 1'b1;
      tick(1);
      FaultClr = 1'b0;
      StartCmd = 1'b1;
      BusReady = 1'b1;
      tick(1);
      n_checks++;
      if ({SeqState, FaultCause} !== {3'd1, 2'd0}) begin
         n_errors++;
         $display("FAIL cause_cleared: got state=%0d cause=%0d expected 1 0", SeqState, FaultCause);
      end
   endtask

   task automatic test_async_reset();
      go_run();
      n_checks++;
      if (PwmEn !== 1'b1) begin
         n_errors++;
         $display("FAIL async_run_entry: got %0d expected 1", PwmEn);
      end
      #2;
      RSTn = 1'b0;
      #1;
      n_checks++;
      if ({PwmEn, SeqState} !== 4'b0_000) begin
         n_errors++;
         $display("FAIL async_reset: got pwm=%0d state=%0d expected 0 0", PwmEn, SeqState);
      end
      StartCmd = 1'b0;
      #3;
      RSTn = 1'b1;
      tick(2);
      n_checks++;
      if ({SeqState, TripCount, RetryCount} !== {3'd0, 4'd0, 3'd0}) begin
         n_errors++;
         $display("FAIL post_reset: got state=%0d trip=%0d retry=%0d expected 0 0 0",
                  SeqState, TripCount, RetryCount);
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_stop();
      test_trip_retry();
      test_window();
      test_retries_fault();
      test_prechg_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
